// File: rtl/redmule_tcdm_responder.sv
// Banked multi-port TCDM responder: per-port req/gnt with fixed-priority bank
// arbitration, optional LFSR-driven grant stalls and one-cycle read/write responses.
module redmule_tcdm_responder #(
    parameter int unsigned MP        = 4,
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 32,
    parameter int unsigned MEM_WORDS = 4096,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_en_i,
    input  logic [MP-1:0]        tcdm_req_i,
    output logic [MP-1:0]        tcdm_gnt_o,
    input  logic [MP*AW-1:0]     tcdm_add_i,
    input  logic [MP-1:0]        tcdm_wen_i,
    input  logic [MP*DW/8-1:0]   tcdm_be_i,
    input  logic [MP*DW-1:0]     tcdm_data_i,
    output logic [MP*DW-1:0]     tcdm_r_data_o,
    output logic [MP-1:0]        tcdm_r_valid_o,
    output logic                 tcdm_r_opc_o,
    output logic                 tcdm_r_user_o,
    output logic [31:0]          gnt_count_o
);

    localparam int unsigned BW   = DW / 8;
    localparam int unsigned OFF  = (BW > 1) ? $clog2(BW) : 0;
    localparam int unsigned ROWS = MEM_WORDS / MP;
    localparam int unsigned BKW  = (MP > 1) ? $clog2(MP) : 1;
    localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [DW-1:0]    mem_q [MP][ROWS];
    logic [AW-1:0]    word  [MP];
    logic [BKW-1:0]   bank  [MP];
    logic [RW-1:0]    row   [MP];
    logic [MP-1:0]    oor, stall, conflict, gnt;

    logic [15:0]      lfsr_q, lfsr_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [32:0]      cnt_sum;
    logic [MP*DW-1:0] rdata_q;
    logic [MP-1:0]    rvalid_q;
    logic             opc_q;

    always_comb begin
        oor      = '0;
        stall    = '0;
        conflict = '0;
        for (int unsigned i = 0; i < MP; i++) begin
            word[i]  = tcdm_add_i[i*AW +: AW] >> OFF;
            bank[i]  = BKW'(word[i] % AW'(MP));
            row[i]   = RW'(word[i] / AW'(MP));
            oor[i]   = (word[i] / AW'(MP)) >= AW'(ROWS);
            stall[i] = stall_en_i & lfsr_q[i];
        end
        // A stalled port does not claim its bank, so a higher port may take it.
        for (int unsigned i = 1; i < MP; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (tcdm_req_i[j] && !stall[j] && (bank[j] == bank[i]))
                    conflict[i] = 1'b1;
            end
        end
        gnt = tcdm_req_i & ~stall & ~conflict & {MP{~rst_i}};
    end

    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        for (int unsigned i = 0; i < MP; i++)
            cnt_sum = cnt_sum + 33'(gnt[i]);
        cnt_d  = cnt_sum[32] ? '1 : cnt_sum[31:0];
        lfsr_d = stall_en_i ? {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]}
                            : lfsr_q;
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < MP; i++) begin
            if (gnt[i] && !tcdm_wen_i[i] && !oor[i]) begin
                for (int unsigned k = 0; k < BW; k++) begin
                    if (tcdm_be_i[i*BW + k])
                        mem_q[bank[i]][row[i]][k*8 +: 8] <= tcdm_data_i[i*DW + k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            opc_q    <= 1'b0;
            cnt_q    <= '0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            rvalid_q <= gnt;
            opc_q    <= |(gnt & oor);
            cnt_q    <= cnt_d;
            lfsr_q   <= lfsr_d;
            for (int unsigned i = 0; i < MP; i++) begin
                if (gnt[i])
                    rdata_q[i*DW +: DW] <= (tcdm_wen_i[i] && !oor[i]) ? mem_q[bank[i]][row[i]] : '0;
            end
        end
    end

    assign tcdm_gnt_o     = gnt;
    assign tcdm_r_data_o  = rdata_q;
    assign tcdm_r_valid_o = rvalid_q;
    assign tcdm_r_opc_o   = opc_q;
    assign tcdm_r_user_o  = 1'b0;
    assign gnt_count_o    = cnt_q;

endmodule
